// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: one outstanding word request, registered instruction out to decode.
// Optional misaligned-redirect trap is compiled in with `define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    , FAULT
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        squash_reg, squash_next;
  logic [31:0] inst_reg, inst_pc_reg;
  logic        capture;
  logic        req_valid_reg, inst_valid_reg;
  logic        redirect_take;
  logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_take;
  logic fault_reg;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    squash_next   = squash_reg;
    capture       = 1'b0;
    redirect_take = redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_take    = redirect_valid && (state_reg != FAULT) && (redirect_pc[1:0] != 2'b00);
    redirect_take = redirect_valid && (state_reg != FAULT) && (redirect_pc[1:0] == 2'b00);
`endif

    case (state_reg)
      IDLE: state_next = REQ;
      REQ:  if (imem_req_ready) state_next = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          if (squash_reg) begin
            state_next  = REQ;
            squash_next = 1'b0;
          end else begin
            state_next = HOLD;
            capture    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          state_next = REQ;
          pc_next    = pc_reg + 32'd4;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: state_next = FAULT;
`endif
      default: state_next = IDLE;
    endcase

    // A redirect overrides whatever the state case decided this cycle.
    if (redirect_take) begin
      pc_next = redirect_target;
      capture = 1'b0;
      case (state_reg)
        REQ:  squash_next = imem_req_ready;
        WAIT: begin
          state_next  = imem_rsp_valid ? REQ : WAIT;
          squash_next = !imem_rsp_valid;
        end
        default: state_next = REQ;
      endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    if (fault_take) begin
      state_next  = FAULT;
      pc_next     = pc_reg;
      squash_next = 1'b0;
      capture     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC_ALIGNED;
      squash_reg     <= 1'b0;
      inst_reg       <= NOP_WORD;
      inst_pc_reg    <= RESET_PC_ALIGNED;
      req_valid_reg  <= 1'b0;
      inst_valid_reg <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      squash_reg     <= squash_next;
      req_valid_reg  <= (state_next == REQ);
      inst_valid_reg <= (state_next == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_reg      <= (state_next == FAULT);
`endif
      if (capture) begin
        inst_reg    <= imem_rsp_data;
        inst_pc_reg <= pc_reg;
      end
    end
  end

  assign imem_req_valid = req_valid_reg;
  assign imem_addr      = pc_reg;
  assign inst_valid     = inst_valid_reg;
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault    = fault_reg;
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory plus scoreboard queues of
// expected request addresses and expected {pc, word} deliveries to decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          pop_cyc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  // memory model state
  bit          mem_ready_en = 1'b0;
  int          mem_lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] pending_data = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0000_2103;
      default:       return (a << 7) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    return e;
  endfunction

  // Called at a falling edge with DUT-facing inputs already set; checks, drives memory, advances one cycle.
  task automatic tick();
    exp_t        e;
    logic [31:0] a;
    if (inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("inst_unexpected", {31'b0, inst_valid}, 32'h0);
      end else begin
        e = exp_q[0];
        chk("inst", inst, e.word);
        chk("inst_pc", inst_pc, e.pc);
        if (inst_ready && !redirect_valid) begin
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
    imem_rsp_valid = 1'b0;
    if (pending) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pending_data;
        pending        = 1'b0;
      end else begin
        cnt--;
      end
    end
    imem_req_ready = 1'b0;
    if (imem_req_valid === 1'b1 && mem_ready_en) begin
      imem_req_ready = 1'b1;
      if (exp_addr_q.size() == 0) begin
        chk("req_unexpected", {31'b0, imem_req_valid}, 32'h0);
      end else begin
        a = exp_addr_q.pop_front();
        chk("req_addr", imem_addr, a);
      end
      pending      = 1'b1;
      cnt          = mem_lat - 1;
      pending_data = ovr_en ? ovr_data : mem_word(imem_addr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() > 0 && g < 60) begin
      tick();
      g++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_hold(input string tag);
    int g = 0;
    while (inst_valid !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    chk({tag, "_hold"}, {31'b0, inst_valid}, 32'h1);
  endtask

  task automatic do_reset();
    mem_ready_en   = 1'b0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    rst          = 1'b0;
    mem_ready_en = 1'b1;
    tick();
    chk("first_req", {31'b0, imem_req_valid}, 32'h1);
  endtask

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    do_reset();

    // Two back-to-back fetches, 1-cycle memory, decode always ready
    mem_lat    = 1;
    inst_ready = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_q.push_back(mk(32'h0, 32'h0050_0093));
    exp_q.push_back(mk(32'h4, 32'h0000_2103));
    drain("s1");
    chk("s1_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);

    // Redirect and inst_ready together in HOLD at 0x8
    inst_ready = 1'b0;
    exp_addr_q.push_back(32'h8);
    exp_q.push_back(mk(32'h8, mem_word(32'h8)));
    wait_hold("s2");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    void'(exp_q.pop_front());
    chk("s2_addr", imem_addr, 32'h40);
    chk("s2_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("s2_inst_valid", {31'b0, inst_valid}, 32'h0);

    // Backpressure: decode stalls 5 cycles in HOLD
    exp_addr_q.push_back(32'h40);
    exp_q.push_back(mk(32'h40, mem_word(32'h40)));
    wait_hold("s3");
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("bp_addr", imem_addr, 32'h40);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp_adv_addr", imem_addr, 32'h44);
    chk("bp_adv_req", {31'b0, imem_req_valid}, 32'h1);

    // Redirect in WAIT; stale 0xDEADBEEF lands two cycles later and must be dropped
    exp_addr_q.push_back(32'h44);
    mem_lat  = 3;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    tick();
    ovr_en  = 1'b0;
    mem_lat = 1;
    chk("s4_in_wait", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("s4_addr", imem_addr, 32'h100);
    chk("s4_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("s4_inst_valid", {31'b0, inst_valid}, 32'h0);
    exp_addr_q.push_back(32'h100);
    exp_q.push_back(mk(32'h100, mem_word(32'h100)));
    inst_ready = 1'b1;
    drain("s4");

    // PC wrap from the top of the address space
    mem_ready_en   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    mem_ready_en = 1'b1;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_q.push_back(mk(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)));
    exp_q.push_back(mk(32'h0, 32'h0050_0093));
    drain("s5");

    // Misaligned redirect to 0x102
    mem_ready_en   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    mem_ready_en   = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
      chk("mis_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("mis_inst_valid", {31'b0, inst_valid}, 32'h0);
      tick();
    end
`else
    chk("mis_fault", {31'b0, fetch_fault}, 32'h0);
    chk("mis_addr", imem_addr, 32'h100);
    exp_addr_q.push_back(32'h100);
    exp_q.push_back(mk(32'h100, mem_word(32'h100)));
    drain("s6");
`endif

    // Reset while a request is outstanding; the late response must be ignored
    do_reset();
    exp_addr_q.push_back(32'h0);
    mem_lat = 2;
    tick();
    chk("s7_in_wait", {31'b0, imem_req_valid}, 32'h0);
    mem_ready_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("s7_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("s7_inst", inst, 32'h0000_0013);
    chk("s7_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("s7_addr", imem_addr, 32'h0);
    mem_ready_en = 1'b1;
    mem_lat      = 1;
    exp_addr_q.push_back(32'h0);
    exp_q.push_back(mk(32'h0, 32'h0050_0093));
    inst_ready = 1'b1;
    drain("s7");
    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
